// File: rtl/sample_loader_pkg.sv
// Shared definitions for the sample loader.
// Holds the loader FSM state encoding and the default buffer geometry
// (entry count, sample width and the width of the running sum).
package sample_loader_pkg;

  localparam int N_DEF = 32;
  localparam int W_DEF = 8;
  localparam int SUM_W = W_DEF + $clog2(N_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_e;

endpackage

// File: rtl/sample_loader_counter.sv
// Synchronous up-counter with clear and enable.
// Ports:
//   clk      - clock
//   rst_n    - asynchronous active-low reset, forces count to 0
//   i_clr    - synchronous clear (wins over enable)
//   i_en     - increment by one this cycle
//   o_count  - current count
module sample_loader_counter #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/sample_loader.sv
// Sample loader: fills an N-entry flip-flop buffer from a valid/ready
// sample stream, keeps a running sum, and hands the full buffer to the
// mean data path until it reports consume_done.
//
// state | meaning
// IDLE  | waiting for start; buffer contents retained
// LOAD  | accepting samples, in_ready=1
// FULL  | all N entries written; contents frozen until consume_done
//
// Ports:
//   clk          - clock, rising edge
//   reset        - asynchronous active-low reset
//   start        - begin a new fill (honoured only in IDLE)
//   in_valid     - in_data carries a sample
//   in_data      - sample value
//   in_ready     - loader accepts a sample this cycle (registered)
//   consume_done - reader finished with the buffer (honoured only in FULL)
//   mem_out      - buffer contents, readable combinationally
//   buf_full     - buffer full and stable (registered)
//   wr_count     - samples accepted in the current fill
//   sum          - running unsigned sum of accepted samples
module sample_loader
  import sample_loader_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    in_valid,
  input  logic [W-1:0]            in_data,
  output logic                    in_ready,
  input  logic                    consume_done,
  output logic [W-1:0]            mem_out [0:N-1],
  output logic                    buf_full,
  output logic [$clog2(N):0]      wr_count,
  output logic [W+$clog2(N)-1:0]  sum
);

  localparam int AW = $clog2(N);

  state_e            r_state;
  logic              r_in_ready;
  logic              r_buf_full;
  logic [W+AW-1:0]   r_sum;
  logic [W-1:0]      r_mem [0:N-1];

  logic              w_xfer;
  logic              w_clr;
  logic              w_last;
  logic [AW:0]       w_wr_count;

  // in_ready is a flop, so the transfer strobe has no path from in_valid
  // back to in_ready.
  assign w_xfer = in_valid & r_in_ready;
  assign w_clr  = (r_state == IDLE) & start;
  assign w_last = (w_wr_count[AW-1:0] == AW'(N - 1));

  sample_loader_counter #(
    .WIDTH (AW + 1)
  ) u_wr_ptr (
    .clk     (clk),
    .rst_n   (reset),
    .i_clr   (w_clr),
    .i_en    (w_xfer),
    .o_count (w_wr_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b0;
      r_buf_full <= 1'b0;
      r_sum      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= LOAD;
            r_in_ready <= 1'b1;
            r_sum      <= '0;
          end
        end
        LOAD: begin
          if (w_xfer) begin
            r_sum <= r_sum + {{AW{1'b0}}, in_data};
            if (w_last) begin
              r_state    <= FULL;
              r_in_ready <= 1'b0;
              r_buf_full <= 1'b1;
            end
          end
        end
        FULL: begin
          // consume_done wins over a simultaneous start: no new fill.
          if (consume_done) begin
            r_state    <= IDLE;
            r_buf_full <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
          r_buf_full <= 1'b0;
        end
      endcase
    end
  end

  // Buffer storage; a transfer only happens in LOAD, so the index is
  // always below N here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_xfer) begin
      r_mem[w_wr_count[AW-1:0]] <= in_data;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_mem_out
    assign mem_out[g] = r_mem[g];
  end

  assign in_ready = r_in_ready;
  assign buf_full = r_buf_full;
  assign wr_count = w_wr_count;
  assign sum      = r_sum;

endmodule

// File: tb/tb_sample_loader.sv
module tb_sample_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        consume_done;
  logic [7:0]  mem_out [0:31];
  logic        buf_full;
  logic [5:0]  wr_count;
  logic [12:0] sum;

  int n_chk;
  int n_fail;

  sample_loader #(.N(32), .W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .consume_done (consume_done),
    .mem_out      (mem_out),
    .buf_full     (buf_full),
    .wr_count     (wr_count),
    .sum          (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int mem_err_ramp();
    int e = 0;
    for (int i = 0; i < 32; i++) if (mem_out[i] !== 8'(i)) e++;
    return e;
  endfunction

  function automatic int mem_err_const(input logic [7:0] v);
    int e = 0;
    for (int i = 0; i < 32; i++) if (mem_out[i] !== v) e++;
    return e;
  endfunction

  // One sample preceded by `gaps` idle cycles (in_valid=0, junk data).
  task automatic send(input logic [7:0] d, input int gaps);
    for (int g = 0; g < gaps; g++) begin
      in_valid = 1'b0;
      in_data  = 8'hA5;
      tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_consume();
    consume_done = 1'b1;
    tick();
    consume_done = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    consume_done = 1'b0;

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_buf_full", 32'(buf_full), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_mem", 32'(mem_err_const(8'h00)), 32'd0);
    reset = 1'b1;
    tick();

    // Idle: samples without start are not taken
    in_valid = 1'b1; in_data = 8'h33;
    tick(); tick();
    in_valid = 1'b0;
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    chk("idle_wr_count", 32'(wr_count), 32'd0);

    // Fill 1: ramp 0..31 back to back
    do_start();
    chk("f1_in_ready", 32'(in_ready), 32'd1);
    chk("f1_wr_count0", 32'(wr_count), 32'd0);
    for (int i = 0; i < 32; i++) begin
      if (i == 31) begin
        chk("f1_pre_full", 32'(buf_full), 32'd0);
        chk("f1_wr_count31", 32'(wr_count), 32'd31);
      end
      in_valid = 1'b1; in_data = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("f1_buf_full", 32'(buf_full), 32'd1);
    chk("f1_in_ready", 32'(in_ready), 32'd0);
    chk("f1_wr_count", 32'(wr_count), 32'd32);
    chk("f1_sum", 32'(sum), 32'd496);
    chk("f1_mem", 32'(mem_err_ramp()), 32'd0);

    // FULL is frozen against data and start
    in_valid = 1'b1; in_data = 8'h55; start = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0; start = 1'b0;
    chk("hold_sum", 32'(sum), 32'd496);
    chk("hold_wr_count", 32'(wr_count), 32'd32);
    chk("hold_mem", 32'(mem_err_ramp()), 32'd0);
    chk("hold_buf_full", 32'(buf_full), 32'd1);
    do_consume();
    chk("cons_buf_full", 32'(buf_full), 32'd0);
    chk("cons_in_ready", 32'(in_ready), 32'd0);
    chk("cons_mem", 32'(mem_err_ramp()), 32'd0);

    // Fill 2: 0xFF with gaps of 0..2 idle cycles
    do_start();
    chk("f2_sum_clr", 32'(sum), 32'd0);
    chk("f2_wr_clr", 32'(wr_count), 32'd0);
    for (int i = 0; i < 32; i++) begin
      send(8'hFF, i % 3);
      if (i == 4) begin
        in_valid = 1'b0; in_data = 8'hFF;
        tick(); tick();
        chk("f2_gap_wr_count", 32'(wr_count), 32'd5);
        chk("f2_gap_sum", 32'(sum), 32'd1275);
      end
    end
    chk("f2_sum", 32'(sum), 32'h1FE0);
    chk("f2_wr_count", 32'(wr_count), 32'd32);
    chk("f2_in_ready", 32'(in_ready), 32'd0);
    chk("f2_buf_full", 32'(buf_full), 32'd1);
    chk("f2_mem", 32'(mem_err_const(8'hFF)), 32'd0);
    do_consume();

    // Fill 3: 100 each, sum restarts
    do_start();
    chk("f3_wr_clr", 32'(wr_count), 32'd0);
    for (int i = 0; i < 32; i++) send(8'd100, 0);
    chk("f3_sum", 32'(sum), 32'd3200);
    chk("f3_buf_full", 32'(buf_full), 32'd1);

    // start + consume_done together in FULL -> IDLE, no new fill
    start = 1'b1; consume_done = 1'b1;
    tick();
    start = 1'b0; consume_done = 1'b0;
    chk("both_buf_full", 32'(buf_full), 32'd0);
    chk("both_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 8'h11;
    tick(); tick(); tick();
    in_valid = 1'b0;
    chk("both_in_ready2", 32'(in_ready), 32'd0);
    chk("both_sum", 32'(sum), 32'd3200);
    chk("both_mem", 32'(mem_err_const(8'd100)), 32'd0);

    // Fill 4 aborted by reset after 10 samples
    do_start();
    for (int i = 0; i < 10; i++) send(8'(i + 1), 0);
    chk("f4_sum", 32'(sum), 32'd55);
    chk("f4_wr_count", 32'(wr_count), 32'd10);
    #2 reset = 1'b0;
    #1;
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_wr_count", 32'(wr_count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_buf_full", 32'(buf_full), 32'd0);
    chk("arst_mem", 32'(mem_err_const(8'h00)), 32'd0);
    reset = 1'b1;
    in_valid = 1'b1; in_data = 8'h77;
    for (int i = 0; i < 5; i++) tick();
    in_valid = 1'b0;
    chk("post_rst_wr_count", 32'(wr_count), 32'd0);
    chk("post_rst_sum", 32'(sum), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd0);
    chk("post_rst_mem", 32'(mem_err_const(8'h00)), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
